// File: rtl/mem_port_arbiter_if.sv
// Port bundle for mem_port_arbiter: the three requester handshakes plus the
// single-port memory strobe/address/data lines.
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;

  logic          stall_if;
  logic          stall_mem;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata,
    output stall_if, stall_mem,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // System side: requesters and the memory macro
  modport master (
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata,
    input  stall_if, stall_mem,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter in front of the unified single-port memory: data port,
// instruction fetch and loader, with loader anti-starvation and tagged read return.
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic               clk1,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  // The owner tag also serves as the read-pending flag (anything but NONE).
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_D,
    OWN_I,
    OWN_L
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [DW-1:0] d_rdata_q, i_rdata_q, l_rdata_q;

  logic          promote;
  logic          gnt_d, gnt_i, gnt_l;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign promote = bus.l_req && (starve_cnt_q == STARVE_LIM);

  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    gnt_l = 1'b0;
    if (!rst) begin
      if (promote) begin
        gnt_l = 1'b1;
      end else if (bus.d_req) begin
        gnt_d = 1'b1;
      end else if (bus.i_req) begin
        gnt_i = 1'b1;
      end else if (bus.l_req) begin
        gnt_l = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_d) begin
      sel_we    = bus.d_we;
      sel_addr  = bus.d_addr;
      sel_wdata = bus.d_wdata;
    end else if (gnt_i) begin
      sel_addr  = bus.i_addr;
    end else if (gnt_l) begin
      sel_we    = bus.l_we;
      sel_addr  = bus.l_addr;
      sel_wdata = bus.l_wdata;
    end
  end

  assign bus.d_gnt     = gnt_d;
  assign bus.i_gnt     = gnt_i;
  assign bus.l_gnt     = gnt_l;
  assign bus.mem_en    = gnt_d | gnt_i | gnt_l;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  // Loader wait counter: counts consecutive lost cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.l_req || gnt_l) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt_d && !bus.d_we) begin
      owner_d = OWN_D;
    end else if (gnt_i) begin
      owner_d = OWN_I;
    end else if (gnt_l && !bus.l_we) begin
      owner_d = OWN_L;
    end
  end

  // Response cycle passes memory data straight through; afterwards the copy is held.
  always_comb begin
    bus.d_rvalid  = (owner_q == OWN_D);
    bus.i_rvalid  = (owner_q == OWN_I);
    bus.l_rvalid  = (owner_q == OWN_L);
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : d_rdata_q;
    bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : i_rdata_q;
    bus.l_rdata   = bus.l_rvalid ? bus.mem_rdata : l_rdata_q;
    bus.stall_if  = bus.i_req && !gnt_i && !rst;
    bus.stall_mem = bus.d_req && !gnt_d && !rst;
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      d_rdata_q <= '0;
      i_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      if (owner_q == OWN_D) begin
        d_rdata_q <= bus.mem_rdata;
      end
      if (owner_q == OWN_I) begin
        i_rdata_q <= bus.mem_rdata;
      end
      if (owner_q == OWN_L) begin
        l_rdata_q <= bus.mem_rdata;
      end
    end
  end

  a_one_grant : assert property (@(posedge clk1) disable iff (rst)
    $onehot0({gnt_d, gnt_i, gnt_l}));

  a_promoted_loader_wins : assert property (@(posedge clk1) disable iff (rst)
    promote |-> gnt_l);

  a_starve_bounded : assert property (@(posedge clk1) disable iff (rst)
    starve_cnt_q <= STARVE_LIM);

  a_one_response : assert property (@(posedge clk1) disable iff (rst)
    $onehot0({bus.d_rvalid, bus.i_rvalid, bus.l_rvalid}));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a memory behind the port, a reference
// model of the arbitration rules checked every cycle, plus literal spot checks.
module tb_mem_port_arbiter;

  localparam int AW     = 10;
  localparam int DW     = 32;
  localparam int STARVE = 8;

  logic clk1 = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clk1 = ~clk1;

  // Preloaded memory image: every word carries its own address in the low bits.
  function automatic logic [31:0] preload(input logic [9:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  logic [31:0] mem [1024];
  bit          memWritten [1024];

  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr]        <= bus.mem_wdata;
        memWritten[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= memWritten[bus.mem_addr] ? mem[bus.mem_addr] : preload(bus.mem_addr);
      end
    end
  end

  // Reference model state: 0 = none, 1 = D, 2 = I, 3 = L
  int          mWait;
  int          mPend;
  logic [31:0] mPdata;
  logic [31:0] mHold [4];
  logic [31:0] refMem [1024];
  bit          refWritten [1024];

  logic [31:0] t1Words [4] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

  task automatic expectEq(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] reqDIL, input logic dWe, input logic [9:0] dAddr,
                               input logic [31:0] dWdata, input logic [9:0] iAddr,
                               input logic lWe, input logic [9:0] lAddr, input logic [31:0] lWdata);
    bus.d_req   = reqDIL[2];
    bus.i_req   = reqDIL[1];
    bus.l_req   = reqDIL[0];
    bus.d_we    = dWe;
    bus.d_addr  = dAddr;
    bus.d_wdata = dWdata;
    bus.i_addr  = iAddr;
    bus.l_we    = lWe;
    bus.l_addr  = lAddr;
    bus.l_wdata = lWdata;
  endtask

  task automatic idle();
    applyStimulus(3'b000, 1'b0, 10'h0, 32'h0, 10'h0, 1'b0, 10'h0, 32'h0);
  endtask

  // Compares every output against the model for the current cycle, then advances the model.
  task automatic checkOutput();
    int          win;
    logic        ewe;
    logic [9:0]  eaddr;
    logic [31:0] ewd;
    if (rst) begin
      expectEq("rst_flags", 32'({bus.d_gnt, bus.i_gnt, bus.l_gnt, bus.d_rvalid, bus.i_rvalid,
                                 bus.l_rvalid, bus.stall_if, bus.stall_mem, bus.mem_en, bus.mem_we}), 32'h0);
      expectEq("rst_rdata", bus.d_rdata | bus.i_rdata | bus.l_rdata, 32'h0);
      mWait = 0;
      mPend = 0;
      for (int p = 0; p < 4; p++) mHold[p] = 32'h0;
      return;
    end
    win = 0;
    if (bus.l_req && mWait >= STARVE) win = 3;
    else if (bus.d_req) win = 1;
    else if (bus.i_req) win = 2;
    else if (bus.l_req) win = 3;
    ewe   = 1'b0;
    eaddr = 10'h0;
    ewd   = 32'h0;
    case (win)
      1: begin ewe = bus.d_we; eaddr = bus.d_addr; ewd = bus.d_wdata; end
      2: begin eaddr = bus.i_addr; end
      3: begin ewe = bus.l_we; eaddr = bus.l_addr; ewd = bus.l_wdata; end
      default: ;
    endcase
    expectEq("gnt_dil", 32'({bus.d_gnt, bus.i_gnt, bus.l_gnt}), 32'({win == 1, win == 2, win == 3}));
    expectEq("stall_if", 32'(bus.stall_if), 32'(bus.i_req && win != 2));
    expectEq("stall_mem", 32'(bus.stall_mem), 32'(bus.d_req && win != 1));
    expectEq("mem_en", 32'(bus.mem_en), 32'(win != 0));
    expectEq("mem_we", 32'(bus.mem_we), 32'(win != 0 && ewe));
    if (win != 0) expectEq("mem_addr", 32'(bus.mem_addr), 32'(eaddr));
    if (win != 0 && ewe) expectEq("mem_wdata", bus.mem_wdata, ewd);
    expectEq("rvalid_dil", 32'({bus.d_rvalid, bus.i_rvalid, bus.l_rvalid}),
             32'({mPend == 1, mPend == 2, mPend == 3}));
    expectEq("d_rdata", bus.d_rdata, (mPend == 1) ? mPdata : mHold[1]);
    expectEq("i_rdata", bus.i_rdata, (mPend == 2) ? mPdata : mHold[2]);
    expectEq("l_rdata", bus.l_rdata, (mPend == 3) ? mPdata : mHold[3]);
    if (mPend != 0) mHold[mPend] = mPdata;
    mPend = 0;
    if (win != 0) begin
      if (ewe) begin
        refMem[eaddr]     = ewd;
        refWritten[eaddr] = 1'b1;
      end else begin
        mPend  = win;
        mPdata = refWritten[eaddr] ? refMem[eaddr] : preload(eaddr);
      end
    end
    if (!bus.l_req || win == 3) mWait = 0;
    else if (mWait < STARVE) mWait++;
  endtask

  task automatic toNegedge();
    @(negedge clk1);
    checkOutput();
  endtask

  task automatic toNextCycle();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    toNegedge();
    expectEq("reset_mem_en", 32'(bus.mem_en), 32'h0);
    expectEq("reset_d_rdata", bus.d_rdata, 32'h0);
    expectEq("reset_starve", 32'(dut.starve_cnt_q), 32'h0);
    toNextCycle();
    rst = 1'b0;

    // Back-to-back fetches of words 0..3
    for (int k = 0; k < 4; k++) begin
      applyStimulus(3'b010, 1'b0, 10'h0, 32'h0, 10'(k), 1'b0, 10'h0, 32'h0);
      toNegedge();
      expectEq("t1_i_gnt", 32'(bus.i_gnt), 32'h1);
      if (k > 0) expectEq("t1_i_rdata", bus.i_rdata, t1Words[k-1]);
      toNextCycle();
    end
    idle();
    toNegedge();
    expectEq("t1_i_rvalid_last", 32'(bus.i_rvalid), 32'h1);
    expectEq("t1_i_rdata_last", bus.i_rdata, 32'hC0DE0003);
    toNextCycle();

    // Load and fetch collide: data port first
    applyStimulus(3'b110, 1'b0, 10'h010, 32'h0, 10'h004, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t2_d_gnt", 32'(bus.d_gnt), 32'h1);
    expectEq("t2_stall_if", 32'(bus.stall_if), 32'h1);
    toNextCycle();
    applyStimulus(3'b010, 1'b0, 10'h0, 32'h0, 10'h004, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t2_i_gnt", 32'(bus.i_gnt), 32'h1);
    expectEq("t2_stall_if_clear", 32'(bus.stall_if), 32'h0);
    expectEq("t2_d_rdata", bus.d_rdata, 32'hC0DE0010);
    toNextCycle();
    idle();
    toNegedge();
    expectEq("t2_i_rvalid", 32'(bus.i_rvalid), 32'h1);
    expectEq("t2_i_rdata", bus.i_rdata, 32'hC0DE0004);
    toNextCycle();

    // Store to the top word, then fetch it back
    applyStimulus(3'b100, 1'b1, 10'h3FF, 32'hDEADBEEF, 10'h0, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t3_mem_we", 32'(bus.mem_we), 32'h1);
    expectEq("t3_mem_addr", 32'(bus.mem_addr), 32'h3FF);
    toNextCycle();
    applyStimulus(3'b010, 1'b0, 10'h0, 32'h0, 10'h3FF, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t3_mem_we_pulse", 32'(bus.mem_we), 32'h0);
    expectEq("t3_no_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    toNextCycle();
    idle();
    toNegedge();
    expectEq("t3_i_rdata", bus.i_rdata, 32'hDEADBEEF);
    toNextCycle();

    // Loader starved by saturated D and I traffic
    for (int c = 1; c <= 9; c++) begin
      applyStimulus(3'b111, 1'b0, 10'h030, 32'h0, 10'h040, 1'b0, 10'h020, 32'h0);
      toNegedge();
      expectEq("t4_l_gnt", 32'(bus.l_gnt), 32'(c == 9));
      if (c == 9) expectEq("t4_starve_sat", 32'(dut.starve_cnt_q), 32'h8);
      toNextCycle();
    end
    applyStimulus(3'b110, 1'b0, 10'h030, 32'h0, 10'h040, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t4_starve_clear", 32'(dut.starve_cnt_q), 32'h0);
    expectEq("t4_l_rdata", bus.l_rdata, 32'hC0DE0020);
    toNextCycle();
    applyStimulus(3'b010, 1'b0, 10'h0, 32'h0, 10'h040, 1'b0, 10'h0, 32'h0);
    toNegedge();
    toNextCycle();
    idle();
    toNegedge();
    toNextCycle();

    // Loader request withdrawn before being granted
    applyStimulus(3'b101, 1'b1, 10'h100, 32'h12345678, 10'h0, 1'b0, 10'h101, 32'h0);
    toNegedge();
    toNextCycle();
    idle();
    toNegedge();
    expectEq("t6_no_access", 32'(bus.mem_en), 32'h0);
    toNextCycle();
    toNegedge();
    expectEq("t6_starve_zero", 32'(dut.starve_cnt_q), 32'h0);
    expectEq("t6_no_l_rvalid", 32'(bus.l_rvalid), 32'h0);
    toNextCycle();

    // Reset lands on a granted load; its response must be dropped
    applyStimulus(3'b100, 1'b0, 10'h011, 32'h0, 10'h0, 1'b0, 10'h0, 32'h0);
    toNegedge();
    expectEq("t5_d_gnt", 32'(bus.d_gnt), 32'h1);
    #1;
    rst = 1'b1;
    applyStimulus(3'b010, 1'b0, 10'h0, 32'h0, 10'h005, 1'b0, 10'h0, 32'h0);
    toNextCycle();
    for (int r = 0; r < 2; r++) begin
      toNegedge();
      expectEq("t5_rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
      expectEq("t5_rst_i_gnt", 32'(bus.i_gnt), 32'h0);
      toNextCycle();
    end
    rst = 1'b0;
    toNegedge();
    expectEq("t5_resume_i_gnt", 32'(bus.i_gnt), 32'h1);
    expectEq("t5_no_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    toNextCycle();
    idle();
    toNegedge();
    expectEq("t5_i_rdata", bus.i_rdata, 32'hC0DE0005);
    expectEq("t5_still_no_d_rvalid", 32'(bus.d_rvalid), 32'h0);
    toNextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
